multi_rom: RTL

//  Boot-loadable read-only memory that serves CH independent read channels over one

---
 rtl/multi_rom.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/multi_rom.sv
// Boot-loadable multi-channel ROM: stream-loaded dual-port array, round-robin read arbiter (2 grants/cycle).
// Optional reload path enabled by defining MULTI_ROM_RELOAD_EN.
module multi_rom #(
    parameter int WIDTH = 8,
    parameter int SCALE = 10,
    parameter int CH    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ld_valid,
    output logic                  ld_ready,
    input  logic [WIDTH-1:0]      ld_data,
    input  logic                  ld_last,
    output logic                  ld_done,
    input  logic [CH-1:0]         req,
    input  logic [CH*SCALE-1:0]   addr,
    output logic [CH-1:0]         gnt,
    output logic [CH-1:0]         rvalid,
    output logic [CH*WIDTH-1:0]   rdata
`ifdef MULTI_ROM_RELOAD_EN
    ,
    input  logic                  reload
`endif
);

    localparam int PW    = (CH > 1) ? $clog2(CH) : 1;
    localparam int DEPTH = 1 << SCALE;

    localparam logic [1:0] ST_LOAD  = 2'd0;
    localparam logic [1:0] ST_READY = 2'd1;
`ifdef MULTI_ROM_RELOAD_EN
    localparam logic [1:0] ST_DRAIN = 2'd2;
`endif

    logic [1:0]       state;
    logic [SCALE-1:0] ld_addr;
    logic             load_beat;
    logic             last_beat;

    logic [PW-1:0]    rr_ptr;
    logic [PW-1:0]    rr_next;
    logic [PW-1:0]    p0_sel, p1_sel;
    logic             p0_hit, p1_hit;
    logic [PW-1:0]    p0_ch, p1_ch;
    logic             p0_v, p1_v;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] rd0, rd1;
    logic [SCALE-1:0] a0, a1;

    assign ld_ready  = (state == ST_LOAD);
    assign ld_done   = (state == ST_READY);
    assign load_beat = (state == ST_LOAD) && ld_valid;
    assign last_beat = load_beat && (ld_last || (ld_addr == {SCALE{1'b1}}));

    // ld_addr stops at the top word: the final beat ends LOAD instead of wrapping.
    // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create ordering races.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_LOAD;
            ld_addr <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (last_beat)
                        state <= ST_READY;
                    else if (load_beat)
                        ld_addr <= ld_addr + 1'b1;
                end
                ST_READY: begin
`ifdef MULTI_ROM_RELOAD_EN
                    if (reload)
                        state <= ST_DRAIN;
`endif
                end
`ifdef MULTI_ROM_RELOAD_EN
                ST_DRAIN: begin
                    state   <= ST_LOAD;
                    ld_addr <= '0;
                end
`endif
                default: state <= ST_LOAD;
            endcase
        end
    end

    // Round-robin scan starting at rr_ptr; first requester takes port 0, second port 1.
    // NOTE: every always_comb output gets a default first, so no path leaves a latch behind.
    always_comb begin
        int idx;
        gnt     = '0;
        p0_hit  = 1'b0;
        p1_hit  = 1'b0;
        p0_sel  = '0;
        p1_sel  = '0;
        rr_next = rr_ptr;
        idx     = 0;
        if (state == ST_READY) begin
            for (int k = 0; k < CH; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= CH)
                    idx = idx - CH;
                if (req[idx] && !p1_hit) begin
                    if (!p0_hit) begin
                        p0_hit = 1'b1;
                        p0_sel = PW'(idx);
                    end else begin
                        p1_hit = 1'b1;
                        p1_sel = PW'(idx);
                    end
                    gnt[idx] = 1'b1;
                    rr_next  = (idx == CH - 1) ? '0 : PW'(idx + 1);
                end
            end
        end
    end

    assign a0 = (state == ST_LOAD) ? ld_addr : addr[int'(p0_sel)*SCALE +: SCALE];
    assign a1 = addr[int'(p1_sel)*SCALE +: SCALE];

    // NOTE: the array and its read registers are not reset; contents are undefined until loaded and rdata is gated by rvalid.
    always_ff @(posedge clk) begin
        if (load_beat)
            mem[a0] <= ld_data;
        rd0 <= mem[a0];
        rd1 <= mem[a1];
    end

    // Port map follows the read data by one cycle so each port's word lands on its channel.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
            p0_v   <= 1'b0;
            p1_v   <= 1'b0;
            p0_ch  <= '0;
            p1_ch  <= '0;
        end else begin
            rr_ptr <= rr_next;
            p0_v   <= p0_hit;
            p1_v   <= p1_hit;
            p0_ch  <= p0_sel;
            p1_ch  <= p1_sel;
        end
    end

    always_comb begin
        rvalid = '0;
        rdata  = '0;
        for (int i = 0; i < CH; i++) begin
            if (p0_v && (p0_ch == PW'(i))) begin
                rvalid[i]              = 1'b1;
                rdata[i*WIDTH +: WIDTH] = rd0;
            end else if (p1_v && (p1_ch == PW'(i))) begin
                rvalid[i]              = 1'b1;
                rdata[i*WIDTH +: WIDTH] = rd1;
            end
        end
    end

endmodule
